// File: rtl/srwpl_pkg.sv
// Shared definitions for the universal shift register sequencer.
package srwpl_pkg;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

endpackage

// File: rtl/srwpl_serial_ctrl.sv
// Sequencer: loads one word into the external shift register, then shifts it
// out N bits on a serial valid/ready stream (fill or rotate, either direction).
module srwpl_serial_ctrl
  import srwpl_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [N-1:0] s_data,
  input  logic         s_dir,
  input  logic         s_rot,
  input  logic         s_fill,
  output logic [1:0]   sr_sel,
  output logic [N-1:0] sr_load_data,
  output logic         sr_i_right,
  output logic         sr_i_left,
  input  logic [N-1:0] sr_q,
  output logic         ser_valid,
  output logic         ser_bit,
  output logic         ser_last,
  input  logic         ser_ready,
  output logic         busy
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               dir_r, rot_r, fill_r;
  logic               shifting, last;

  assign shifting = (state == ST_SHIFT);
  assign last     = shifting && (cnt == CNT_W'(N-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      dir_r  <= 1'b0;
      rot_r  <= 1'b0;
      fill_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (s_valid) begin
          state  <= ST_SHIFT;
          cnt    <= '0;
          dir_r  <= s_dir;
          rot_r  <= s_rot;
          fill_r <= s_fill;
        end
        ST_SHIFT: if (ser_ready) begin
          if (last) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Load is gated by rst_n so a held s_valid cannot clobber the register during reset.
  always_comb begin
    sr_sel = SEL_HOLD;
    if (shifting && ser_ready)          sr_sel = dir_r ? SEL_SHL : SEL_SHR;
    else if (!shifting && s_valid && rst_n) sr_sel = SEL_LOAD;
  end

  assign sr_load_data = s_data;
  assign s_ready      = !shifting;
  assign busy         = shifting;
  assign ser_valid    = shifting;
  assign ser_last     = last;
  assign ser_bit      = dir_r ? sr_q[N-1] : sr_q[0];
  assign sr_i_right   = rot_r ? sr_q[0]   : fill_r;
  assign sr_i_left    = rot_r ? sr_q[N-1] : fill_r;

endmodule

// File: tb/tb_srwpl_serial_ctrl.sv
// Bench for srwpl_serial_ctrl with a behavioural shift register and word-level model.
module tb_srwpl_serial_ctrl;
  localparam int N = 8;
  localparam int CNT_W = 4;

  logic         clk = 0, rst_n = 0;
  logic         s_valid = 0, s_ready, s_dir = 0, s_rot = 0, s_fill = 0;
  logic [N-1:0] s_data = '0, sr_load_data, sr_q;
  logic [1:0]   sr_sel;
  logic         sr_i_right, sr_i_left, ser_valid, ser_bit, ser_last, ser_ready = 1, busy;

  srwpl_serial_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_dir(s_dir), .s_rot(s_rot), .s_fill(s_fill), .sr_sel(sr_sel),
    .sr_load_data(sr_load_data), .sr_i_right(sr_i_right), .sr_i_left(sr_i_left),
    .sr_q(sr_q), .ser_valid(ser_valid), .ser_bit(ser_bit), .ser_last(ser_last),
    .ser_ready(ser_ready), .busy(busy));

  always #5 clk = ~clk;

  // The shift register itself (no reset: contents survive a controller reset)
  always_ff @(posedge clk)
    case (sr_sel)
      2'b01: sr_q <= {sr_i_right, sr_q[N-1:1]};
      2'b10: sr_q <= {sr_q[N-2:0], sr_i_left};
      2'b11: sr_q <= sr_load_data;
      default: ;
    endcase

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Expected register contents after k shifts of word d
  function automatic int exp_q(int d, bit dir, bit rot, bit fill, int k);
    int mask = (1 << N) - 1;
    int keep, inj;
    if (!dir) begin
      keep = d >> k;
      inj  = rot ? (d << (N-k)) : (fill ? (mask << (N-k)) : 0);
    end else begin
      keep = d << k;
      inj  = rot ? (d >> (N-k)) : (fill ? (mask >> (N-k)) : 0);
    end
    return (keep | inj) & mask;
  endfunction

  // Word-level model: which word is in flight and how many bits have left
  bit m_busy = 0, m_dir = 0, m_rot = 0, m_fill = 0, m_qv = 0;
  int m_word = 0, m_idx = 0, m_q = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_idx = 0; m_dir = 0; m_rot = 0; m_fill = 0;
    end else if (!m_busy) begin
      if (s_valid) begin
        m_busy = 1; m_idx = 0; m_word = s_data;
        m_dir = s_dir; m_rot = s_rot; m_fill = s_fill;
        m_q = s_data; m_qv = 1;
      end
    end else if (ser_ready) begin
      m_idx++;
      m_q = exp_q(m_word, m_dir, m_rot, m_fill, m_idx);
      if (m_idx == N) begin m_busy = 0; m_idx = 0; end
    end
  end

  logic [N-1:0] cap;
  int cap_n = 0, last_n = 0;

  always @(negedge clk) begin
    int eb, ebit;
    logic [1:0] esel;
    chk("load_data", sr_load_data, s_data);
    if (!rst_n) begin
      chk("rst_sel", sr_sel, 2'b00);
      chk("rst_valid", ser_valid, 0);
      chk("rst_last", ser_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", s_ready, 1);
    end else begin
      eb = m_busy;
      chk("s_ready", s_ready, !eb);
      chk("busy", busy, eb);
      chk("ser_valid", ser_valid, eb);
      if (eb) begin
        ebit = m_dir ? ((m_word >> (N-1-m_idx)) & 1) : ((m_word >> m_idx) & 1);
        chk("ser_bit", ser_bit, ebit);
        chk("ser_last", ser_last, m_idx == N-1);
        chk("i_right", sr_i_right, m_rot ? m_q[0] : m_fill);
        chk("i_left", sr_i_left, m_rot ? m_q[N-1] : m_fill);
        esel = ser_ready ? (m_dir ? 2'b10 : 2'b01) : 2'b00;
      end else begin
        esel = s_valid ? 2'b11 : 2'b00;
      end
      chk("sr_sel", sr_sel, esel);
      if (m_qv) chk("sr_q", sr_q, m_q[N-1:0]);
      if (ser_valid && ser_ready) begin
        cap = {cap[N-2:0], ser_bit};
        cap_n++;
        if (ser_last) last_n++;
      end
    end
  end

  task automatic accept(input logic [N-1:0] d, input bit dir, rot, fill);
    int i;
    s_data = d; s_dir = dir; s_rot = rot; s_fill = fill; s_valid = 1;
    for (i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (s_ready) break;
    end
    if (i == 40) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    cap_n = 0; last_n = 0; cap = '0;
  endtask

  task automatic wait_bits();
    int i;
    for (i = 0; i < 40 && cap_n < N; i++) begin
      @(negedge clk); #1;
    end
    if (cap_n < N) chk("bits_timeout", cap_n, N);
  endtask

  task automatic finish_word(input string nm, input logic [N-1:0] ecap, input logic [N-1:0] eq);
    wait_bits();
    s_valid = 0;
    chk({nm, "_bits"}, cap, ecap);
    chk({nm, "_lastcnt"}, last_n, 1);
    @(posedge clk); #1;
    chk({nm, "_ready"}, s_ready, 1);
    chk({nm, "_q"}, sr_q, eq);
  endtask

  initial begin
    int cyc;
    #3;
    chk("init_ready", s_ready, 1);
    chk("init_sel", sr_sel, 2'b00);
    chk("init_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;

    // Right shift, fill 0
    accept(8'hC1, 0, 0, 0); s_valid = 0;
    finish_word("right", 8'h83, 8'h00);

    // Left shift
    accept(8'hC1, 1, 0, 0); s_valid = 0;
    finish_word("left", 8'hC1, 8'h00);

    // Rotate right
    accept(8'h5A, 0, 1, 0); s_valid = 0;
    finish_word("rot", 8'h5A, 8'h5A);

    // Fill 1 with backpressure after bit 2
    accept(8'h00, 0, 0, 1); s_valid = 0;
    repeat (2) @(posedge clk);
    #1 ser_ready = 0;
    repeat (3) begin
      @(negedge clk); #1;
      chk("stall_sel", sr_sel, 2'b00);
      chk("stall_bit", ser_bit, 1'b0);
    end
    @(posedge clk); #1 ser_ready = 1;
    finish_word("fill", 8'h00, 8'hFF);

    // s_valid held through SHIFT: next word only taken when s_ready returns
    accept(8'h0F, 0, 0, 0);
    s_data = 8'hA5; s_dir = 1; s_rot = 1; s_fill = 0;
    for (cyc = 1; cyc < 40; cyc++) begin
      @(negedge clk); #1;
      if (s_ready) break;
    end
    chk("hold_gap", cyc, N+1);
    chk("hold_w1_bits", cap, 8'hF0);
    @(posedge clk); #1;
    s_valid = 0; cap_n = 0; last_n = 0; cap = '0;
    @(negedge clk); #1;
    chk("hold_w2_first", ser_valid, 1);
    finish_word("hold_w2", 8'hA5, 8'hA5);

    // Reset mid-word
    accept(8'hC3, 0, 0, 0); s_valid = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_sel", sr_sel, 2'b00);
    chk("mid_rst_valid", ser_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_last", last_n, 0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    accept(8'h96, 1, 0, 0); s_valid = 0;
    finish_word("post_rst", 8'h96, 8'h00);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/srwpl_serial_ctrl.md
Name: srwpl_serial_ctrl

Overview:
Sequencer for the N-bit universal shift register with parallel load. It accepts a parallel word on a valid/ready handshake and issues one parallel load. It then issues N single-bit shifts, left or right, and presents each outgoing bit on a serial valid/ready stream. It supplies the register's serial inputs from either a fill bit or the bit leaving the register (rotate), and reads the register output back to produce the serial bit.

Parameters:
N, 8, shift register width; N >= 2
CNT_W, 4, bit counter width; 2**CNT_W > N

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
s_valid  in  1  input word valid
s_ready  out  1  controller idle, can accept a word
s_data  in  N  word to load
s_dir  in  1  0 = shift right (LSB first), 1 = shift left (MSB first); sampled at accept
s_rot  in  1  1 = rotate, 0 = fill; sampled at accept
s_fill  in  1  fill bit used when s_rot=0; sampled at accept
sr_sel  out  2  register selection: 00 hold, 01 shift right, 10 shift left, 11 parallel load
sr_load_data  out  N  register data_in
sr_i_right  out  1  serial in for shift right (enters at MSB)
sr_i_left  out  1  serial in for shift left (enters at LSB)
sr_q  in  N  register data_out
ser_valid  out  1  serial bit valid
ser_bit  out  1  serial bit
ser_last  out  1  marks the Nth bit of the word
ser_ready  in  1  serial consumer ready
busy  out  1  high in SHIFT state

Behaviour:
- Register semantics:
  - Shift right: q <= {i_right, q[N-1:1]}; the bit leaving is q[0].
  - Shift left: q <= {q[N-2:0], i_left}; the bit leaving is q[N-1].
- States: IDLE and SHIFT. Registered state holds state, cnt[CNT_W-1:0], dir_r, rot_r and fill_r.
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; cnt, dir_r, rot_r and fill_r go to 0.
  - Outputs: sr_sel=00, ser_valid=0, ser_last=0, busy=0, s_ready=1.
  - sr_load_data follows s_data.
- IDLE:
  - s_ready=1 and sr_load_data=s_data.
  - If s_valid: sr_sel=11 (the load lands on this edge), capture dir/rot/fill, set cnt=0, go to SHIFT.
  - Otherwise sr_sel=00.
- SHIFT:
  - s_ready=0, busy=1, ser_valid=1.
  - ser_bit = dir_r ? sr_q[N-1] : sr_q[0].
  - ser_last = (cnt == N-1).
  - If ser_ready: sr_sel = dir_r ? 10 : 01, and cnt increments. If ser_last is also high, go to IDLE and set cnt=0.
  - If ser_ready is low: sr_sel=00, cnt holds, ser_bit stays stable.
- Serial inputs (combinational, both driven always):
  - sr_i_right = rot_r ? sr_q[0] : fill_r.
  - sr_i_left = rot_r ? sr_q[N-1] : fill_r.
- Timing:
  - Word accepted at edge T; first bit valid in cycle T+1.
  - With ser_ready held high, the last bit is in cycle T+N and s_ready is high again in cycle T+N+1.
  - Throughput is N+1 cycles per word.
- Boundaries:
  - s_valid while in SHIFT is ignored (no accept).
  - Rotate leaves the register equal to the loaded word after N shifts.
  - Reset mid-word abandons the word with no ser_last pulse; the register contents are not touched beyond sr_sel=00.
  - cnt never exceeds N-1.
- Only sr_sel, the ser_* outputs, s_ready and the serial inputs are combinational decodes of state, cnt and sr_q. No combinational path from s_valid to s_ready.

Decomposition:
- Shared package srwpl_pkg holds:
  - SEL_HOLD=2'b00, SEL_SHR=2'b01, SEL_SHL=2'b10, SEL_LOAD=2'b11;
  - the state enum {ST_IDLE, ST_SHIFT}.
- No sub-module: FSM and counter live in one module.
- The shift register is instantiated beside this block at top level, not inside it. The bench instantiates both.

Test Plan:
- Right shift: s_data=8'hC1, dir=0, rot=0, fill=0, ser_ready=1 → bits 1,0,0,0,0,0,1,1 in cycles T+1..T+8; ser_last only at T+8; s_ready=1 at T+9; sr_q=8'h00.
- Left shift: s_data=8'hC1, dir=1 → bits 1,1,0,0,0,0,0,1; sr_sel=10 on every shift cycle.
- Rotate: s_data=8'h5A, dir=0, rot=1 → bits 0,1,0,1,1,0,1,0; sr_q=8'h5A after the last bit.
- Fill and backpressure: s_data=8'h00, fill=1, dir=0, ser_ready low for 3 cycles after bit 2 → sr_sel=00 and ser_bit stable during the stall; 8 bits total; final sr_q=8'hFF.
- Busy ignore: s_valid held high with a new word during SHIFT → second word accepted only in the cycle s_ready returns; its first bit appears the next cycle.
- Reset mid-word: rst_n low after 3 bits → immediately sr_sel=00, ser_valid=0, busy=0; after release, the next word produces a full 8 bits with ser_last on bit 8.
